// File: rtl/lfsr_game_pkg.sv
// Purpose: shared constants, FSM state type and length helper for the LFSR pattern buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lfsr_game_pkg;

  localparam int DEPTH  = 16;              // max pattern length (entries)
  localparam int SYM_W  = 2;               // symbol width, taken from lfsr_out LSBs
  localparam int LEN_W  = 5;               // len width; 2**LEN_W > DEPTH
  localparam int LFSR_W = 7;               // LFSR state width
  localparam int ADDR_W = $clog2(DEPTH);   // pattern memory address width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PLAY = 2'd2
  } state_e;

  // A zero or oversize request means "fill the whole memory".
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    if (len == '0 || len > LEN_W'(DEPTH)) begin
      eff_len = LEN_W'(DEPTH);
    end else begin
      eff_len = len;
    end
  endfunction

endpackage

// File: rtl/lfsr_pattern_buffer_mem.sv
// Purpose: DEPTH x SYM_W register file holding the captured pattern.
// Latency: write lands on the clock edge; read is combinational from raddr.
// Backpressure: none; no reset, contents are undefined until written.
// Ports: clk; we/waddr/wdata synchronous write port; raddr/rdata read port.
module pattern_mem #(
  parameter int DEPTH  = 16,
  parameter int SYM_W  = 2,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [SYM_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [SYM_W-1:0]  rdata
);

  logic [SYM_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lfsr_pattern_buffer.sv
// Purpose: enables the LFSR for L cycles, captures one symbol per cycle, then streams the pattern out (replayable).
// Latency: FILL lasts exactly L cycles; first out_valid the cycle after the last capture; one symbol per cycle when ready.
// Backpressure: out_valid/out_ready; out_sym held stable while stalled; start/replay ignored while busy.
// Ports: clk, rst_n (sync, active-low); lfsr_out/lfsr_complete in, lfsr_enable out;
//        start/replay/len control; out_valid/out_ready/out_sym stream; busy, done, wrap_seen, pat_len status.
module lfsr_pattern_buffer
  import lfsr_game_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] lfsr_out,
  input  logic              lfsr_complete,
  output logic              lfsr_enable,
  input  logic              start,
  input  logic              replay,
  input  logic [LEN_W-1:0]  len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  out_sym,
  output logic              busy,
  output logic              done,
  output logic              wrap_seen,
  output logic [LEN_W-1:0]  pat_len
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   wr_idx_q, wr_idx_d;
  logic [LEN_W-1:0]   rd_idx_q, rd_idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   pat_len_q, pat_len_d;
  logic               wrap_seen_q, wrap_seen_d;
  logic               out_valid_q, out_valid_d;
  logic [SYM_W-1:0]   out_sym_q, out_sym_d;
  logic               done_q, done_d;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_raddr;
  logic [SYM_W-1:0]   mem_rdata;
  logic [SYM_W-1:0]   cap_sym;
  logic [LEN_W-1:0]   rd_idx_next;

  // Upper LFSR bits are not part of the symbol.
  logic lfsr_out_unused;
  assign lfsr_out_unused = ^lfsr_out[LFSR_W-1:SYM_W];

  assign cap_sym     = lfsr_out[SYM_W-1:0];
  assign rd_idx_next = rd_idx_q + LEN_W'(1);

  pattern_mem #(
    .DEPTH  (DEPTH),
    .SYM_W  (SYM_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_idx_q[ADDR_W-1:0]),
    .wdata (cap_sym),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    len_d       = len_q;
    pat_len_d   = pat_len_q;
    wrap_seen_d = wrap_seen_q;
    out_valid_d = out_valid_q;
    out_sym_d   = out_sym_q;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    // Read port looks one entry ahead so the next symbol is registered with no bubble.
    mem_raddr   = rd_idx_next[ADDR_W-1:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FILL;
          len_d       = eff_len(len);
          wr_idx_d    = '0;
          wrap_seen_d = 1'b0;
          pat_len_d   = '0;
        end else if (replay && pat_len_q != '0) begin
          state_d     = PLAY;
          rd_idx_d    = '0;
          mem_raddr   = '0;
          out_valid_d = 1'b1;
          out_sym_d   = mem_rdata;
        end
      end

      FILL: begin
        mem_we      = 1'b1;
        wr_idx_d    = wr_idx_q + LEN_W'(1);
        wrap_seen_d = wrap_seen_q | lfsr_complete;
        if (wr_idx_q == len_q - LEN_W'(1)) begin
          state_d     = PLAY;
          pat_len_d   = len_q;
          rd_idx_d    = '0;
          mem_raddr   = '0;
          out_valid_d = 1'b1;
          // With L=1, entry 0 is being written on this very edge: bypass the memory.
          out_sym_d   = (wr_idx_q == '0) ? cap_sym : mem_rdata;
        end
      end

      PLAY: begin
        if (out_valid_q && out_ready) begin
          if (rd_idx_q == pat_len_q - LEN_W'(1)) begin
            state_d     = IDLE;
            rd_idx_d    = '0;
            out_valid_d = 1'b0;
            out_sym_d   = '0;
            done_d      = 1'b1;
          end else begin
            rd_idx_d  = rd_idx_next;
            out_sym_d = mem_rdata;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_sym_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      len_q       <= '0;
      pat_len_q   <= '0;
      wrap_seen_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      len_q       <= len_d;
      pat_len_q   <= pat_len_d;
      wrap_seen_q <= wrap_seen_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      done_q      <= done_d;
    end
  end

  assign lfsr_enable = (state_q == FILL);
  assign busy        = (state_q != IDLE);
  assign out_valid   = out_valid_q;
  assign out_sym     = out_sym_q;
  assign done        = done_q;
  assign wrap_seen   = wrap_seen_q;
  assign pat_len     = pat_len_q;

endmodule

// File: tb/tb_lfsr_pattern_buffer.sv
// Purpose: randomized self-checking bench for lfsr_pattern_buffer against a queue-based pattern model.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: exercises always-ready, 1,0,0,1 and random out_ready patterns.
module tb_lfsr_pattern_buffer;
  import lfsr_game_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [LFSR_W-1:0] lfsr_out;
  logic              lfsr_complete;
  logic              lfsr_enable;
  logic              start;
  logic              replay;
  logic [LEN_W-1:0]  len;
  logic              out_valid;
  logic              out_ready;
  logic [SYM_W-1:0]  out_sym;
  logic              busy;
  logic              done;
  logic              wrap_seen;
  logic [LEN_W-1:0]  pat_len;

  always #5 clk = ~clk;

  lfsr_pattern_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lfsr_out      (lfsr_out),
    .lfsr_complete (lfsr_complete),
    .lfsr_enable   (lfsr_enable),
    .start         (start),
    .replay        (replay),
    .len           (len),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sym       (out_sym),
    .busy          (busy),
    .done          (done),
    .wrap_seen     (wrap_seen),
    .pat_len       (pat_len)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the stored pattern is simply the list of symbols seen while enabled.
  int exp_pat[$];
  int exp_len;
  bit exp_wrap;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Called at a falling edge with the DUT idle; returns at the first PLAY cycle.
  task automatic do_fill(input int l, input bit rep, input int wrap_at, input bit use_tbl);
    int tbl[4] = '{'h69, 'h52, 'h27, 'h4E};
    int cnt;
    int eff;
    eff = (l == 0 || l > DEPTH) ? DEPTH : l;
    start  = 1'b1;
    len    = l[LEN_W-1:0];
    replay = rep;
    @(negedge clk);
    start  = 1'b0;
    replay = 1'b0;
    check("fill_entry_en", lfsr_enable, 1);
    exp_pat.delete();
    exp_wrap = 1'b0;
    cnt = 0;
    while (lfsr_enable && cnt < 40) begin
      check("fill_busy", busy, 1);
      check("fill_valid", out_valid, 0);
      lfsr_out      = use_tbl ? LFSR_W'(tbl[cnt % 4]) : LFSR_W'($urandom);
      lfsr_complete = (cnt == wrap_at);
      exp_pat.push_back(int'(lfsr_out[SYM_W-1:0]));
      exp_wrap = exp_wrap | lfsr_complete;
      start  = 1'($urandom_range(0, 1));
      replay = 1'($urandom_range(0, 1));
      cnt++;
      @(negedge clk);
    end
    start         = 1'b0;
    replay        = 1'b0;
    lfsr_complete = 1'b0;
    lfsr_out      = LFSR_W'($urandom);
    check("fill_cycles", cnt, eff);
    check("pat_len", pat_len, eff);
    check("wrap_seen", wrap_seen, exp_wrap);
    exp_len = eff;
  endtask

  // Called at the first PLAY cycle; mode 0 always ready, 1 = 1,0,0,1 pattern, 2 random.
  task automatic do_play(input int mode);
    int idx;
    int cyc;
    bit rdy;
    idx = 0;
    cyc = 0;
    while (idx < exp_len && cyc < 400) begin
      check("play_valid", out_valid, 1);
      check("play_sym", out_sym, exp_pat[idx]);
      check("play_done_low", done, 0);
      check("play_en_low", lfsr_enable, 0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      start     = 1'($urandom_range(0, 1));
      replay    = 1'($urandom_range(0, 1));
      if (rdy) idx++;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    start     = 1'b0;
    replay    = 1'b0;
    check("play_transfers", idx, exp_len);
    check("done_pulse", done, 1);
    check("idle_valid", out_valid, 0);
    check("idle_sym", out_sym, 0);
    check("idle_busy", busy, 0);
    @(negedge clk);
    check("done_once", done, 0);
    check("still_idle", busy, 0);
    check("pat_len_kept", pat_len, exp_len);
  endtask

  task automatic do_replay(input int mode);
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    do_play(mode);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_en"}, lfsr_enable, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_sym"}, out_sym, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_wrap"}, wrap_seen, 0);
    check({tag, "_patlen"}, pat_len, 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    replay        = 1'b0;
    len           = '0;
    lfsr_out      = '0;
    lfsr_complete = 1'b0;
    out_ready     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    // Replay with nothing stored is ignored.
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    check("empty_replay_busy", busy, 0);
    check("empty_replay_valid", out_valid, 0);

    // Reset during PLAY aborts and invalidates the pattern.
    do_fill(4, 1'b0, -1, 1'b1);
    out_ready = 1'b0;
    @(negedge clk);
    check("stall_valid", out_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_cleared("midplay_rst");
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    check("rst_replay_busy", busy, 0);
    check("rst_replay_patlen", pat_len, 0);

    // Basic fill/play with fixed LFSR values -> 1,2,3,2.
    do_fill(4, 1'b0, -1, 1'b1);
    check("basic_sym0", exp_pat[0], 1);
    check("basic_sym3", exp_pat[3], 2);
    do_play(0);
    do_replay(0);

    // Backpressure 1,0,0,1.
    do_fill(4, 1'b0, -1, 1'b1);
    do_play(1);

    // Length boundaries.
    do_fill(0, 1'b0, -1, 1'b0);
    do_play(0);
    do_fill(20, 1'b0, -1, 1'b0);
    do_play(2);
    do_fill(1, 1'b0, -1, 1'b0);
    do_play(0);
    do_fill(16, 1'b0, -1, 1'b0);
    do_play(1);

    // start+replay together with a valid pattern stored -> FILL wins.
    do_fill(3, 1'b1, -1, 1'b0);
    do_play(0);

    // Wrap flag set on the 3rd FILL cycle, then cleared by a clean fill.
    do_fill(5, 1'b0, 2, 1'b0);
    do_play(0);
    do_replay(1);
    check("wrap_after_replay", wrap_seen, 1);
    do_fill(5, 1'b0, -1, 1'b0);
    do_play(0);

    // Randomized transactions.
    for (int i = 0; i < 10; i++) begin
      do_fill(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 24)), 1'b0);
      do_play(int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) do_replay(int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
